// File: rtl/residue_mon_pkg.sv
// rtl/residue_mon_pkg.sv - state, event-code and width constants for residue_event_monitor
// RESIDUE_CHECK_EN adds the ST_ERR state used by the residue self-check.
package residue_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
`ifdef RESIDUE_CHECK_EN
    , ST_ERR = 2'd3
`endif
  } mon_state_t;

  localparam logic [1:0] EVT_NONE  = 2'b00;
  localparam logic [1:0] EVT_MOD_A = 2'b01;
  localparam logic [1:0] EVT_MOD_B = 2'b10;
  localparam logic [1:0] EVT_BOTH  = 2'b11;

  localparam int MOD_A   = 3;
  localparam int MOD_B   = 7;
  localparam int TOTAL_W = 16;

  function automatic logic [1:0] evt_code_of(input logic zero_a, input logic zero_b);
    if (zero_a && zero_b) return EVT_BOTH;
    else if (zero_a)      return EVT_MOD_A;
    else if (zero_b)      return EVT_MOD_B;
    else                  return EVT_NONE;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - first-word-fall-through event FIFO
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module evt_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          empty,
  output logic          push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign push_ok   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/residue_event_monitor.sv
// rtl/residue_event_monitor.sv - flags counter values whose mod-3/mod-7 residue is zero
// Define RESIDUE_CHECK_EN to add tracker-based residue self-check and the ERR state.
module residue_event_monitor
  import residue_mon_pkg::*;
#(
  parameter int WIDTH = 800,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   cnt1,
  input  logic [WIDTH-1:0]   cnt2,
  input  logic [WIDTH-1:0]   cnt3,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_code,
  output logic [WIDTH-1:0]   evt_stamp,
  output logic [TOTAL_W-1:0] evt_total,
  output logic [TOTAL_W-1:0] drop_total,
  output logic               overflow,
  output logic               err
);

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic [WIDTH-1:0] prev_cnt1;
  logic             seq_ok;
  logic             zero_a;
  logic             zero_b;
  logic             chk_fail;
  logic             push;
  logic             push_ok;
  logic             fifo_empty;
  logic [WIDTH+1:0] head_data;

  assign seq_ok = (cnt1 == prev_cnt1 + WIDTH'(1));
  assign zero_a = (cnt2 == '0);
  assign zero_b = (cnt3 == '0);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_SYNC;
      ST_SYNC: begin
        if (!en)         state_nxt = ST_IDLE;
        else if (seq_ok) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        push = (zero_a || zero_b) && !chk_fail;
`ifdef RESIDUE_CHECK_EN
        if (chk_fail)    state_nxt = ST_ERR;
        else if (!en)    state_nxt = ST_IDLE;
`else
        if (!en)         state_nxt = ST_IDLE;
`endif
      end
`ifdef RESIDUE_CHECK_EN
      ST_ERR:  state_nxt = ST_ERR;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      prev_cnt1 <= '0;
    end else begin
      state     <= state_nxt;
      prev_cnt1 <= cnt1;
    end
  end

`ifdef RESIDUE_CHECK_EN
  logic [1:0] trk_a;
  logic [2:0] trk_b;
  logic [1:0] trk_a_nxt;
  logic [2:0] trk_b_nxt;
  logic       err_q;

  // Trackers hold last cycle's residue; each RUN cycle expects exactly one step.
  assign trk_a_nxt = (trk_a == 2'(MOD_A - 1)) ? 2'd0 : trk_a + 2'd1;
  assign trk_b_nxt = (trk_b == 3'(MOD_B - 1)) ? 3'd0 : trk_b + 3'd1;
  assign chk_fail  = (state == ST_RUN) &&
                     ((cnt2 != WIDTH'(trk_a_nxt)) || (cnt3 != WIDTH'(trk_b_nxt)));
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_a <= '0;
      trk_b <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ST_SYNC && state_nxt == ST_RUN) begin
        trk_a <= cnt2[1:0];
        trk_b <= cnt3[2:0];
      end else if (state == ST_RUN) begin
        trk_a <= trk_a_nxt;
        trk_b <= trk_b_nxt;
      end
      if (chk_fail) err_q <= 1'b1;
    end
  end
`else
  assign chk_fail = 1'b0;
  assign err      = 1'b0;
`endif

  evt_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({evt_code_of(zero_a, zero_b), cnt1}),
    .pop       (evt_valid && evt_ready),
    .head_data (head_data),
    .empty     (fifo_empty),
    .push_ok   (push_ok)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = evt_valid ? head_data[WIDTH+1:WIDTH] : 2'b00;
  assign evt_stamp = evt_valid ? head_data[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_total  <= '0;
      drop_total <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok && evt_total != '1) evt_total <= evt_total + TOTAL_W'(1);
      if (push && !push_ok) begin
        overflow <= 1'b1;
        if (drop_total != '1) drop_total <= drop_total + TOTAL_W'(1);
      end
    end
  end

endmodule

// File: doc/residue_event_monitor.md
RESIDUE_EVENT_MONITOR -- requirements
Module: residue_event_monitor

Interface
REQ-001 Parameter WIDTH, default 800, SHALL be the width of the cnt1/cnt2/cnt3 inputs and of evt_stamp.
REQ-002 Parameter DEPTH, default 4 (power of two, at least 2), SHALL be the number of event FIFO entries.
REQ-003 Port clk, input, 1 bit: SHALL be the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: SHALL be the reset, asynchronous and active-high.
REQ-005 Port en, input, 1 bit: SHALL be the monitor enable.
REQ-006 Ports cnt1, cnt2, cnt3, input, WIDTH bits each: SHALL carry the upstream counter's registered value, value mod 3 and value mod 7, coherent within each cycle.
REQ-007 Ports evt_valid (output, 1) and evt_ready (input, 1): SHALL be the event output handshake.
REQ-008 Port evt_code, output, 2 bits: SHALL be 01 = mod-3 zero only, 10 = mod-7 zero only, 11 = both.
REQ-009 Port evt_stamp, output, WIDTH bits: SHALL be the cnt1 value that produced the event.
REQ-010 Ports evt_total (output, 16 bits) and drop_total (output, 16 bits): SHALL be saturating counts of accepted events and dropped events.
REQ-011 Ports overflow (output, 1) and err (output, 1): SHALL be sticky flags.

Function
REQ-012 States SHALL be IDLE, SYNC and RUN, plus ERR when RESIDUE_CHECK_EN is defined.
REQ-013 Transitions SHALL be:
- IDLE to SYNC when en=1.
- SYNC to RUN when cnt1 equals the previous-cycle cnt1 plus 1, modulo 2^WIDTH (all-ones to 0 qualifies).
- Any state except ERR to IDLE when en=0.
REQ-014 An event SHALL be detected only in RUN, and only when cnt2==0 or cnt3==0; the code is per REQ-008.
REQ-015 A detected event SHALL be pushed at the same edge, so evt_valid rises one cycle after the input sample when the FIFO was empty.
REQ-016 The FIFO SHALL be first-word-fall-through; a transfer occurs when evt_valid and evt_ready are both 1.
REQ-017 When the FIFO is full, a push with a simultaneous pop SHALL be accepted.
REQ-018 When the FIFO is full, a push without a pop SHALL be dropped; overflow is then set and drop_total increments.
REQ-019 evt_total SHALL increment on every accepted push; both counters saturate at 0xFFFF.
REQ-020 Leaving RUN SHALL NOT flush the FIFO; entries remain poppable in every state.

Reset
REQ-021 On rst=1 the block SHALL asynchronously set:
- state to IDLE;
- FIFO empty and evt_valid=0;
- evt_code=0 and evt_stamp=0;
- evt_total=0 and drop_total=0;
- overflow=0 and err=0.
REQ-022 If rst is asserted mid-handshake, the pending event SHALL be discarded without being counted as dropped.

Configuration
REQ-023 The macro RESIDUE_CHECK_EN SHALL enable the residue self-check.
REQ-024 With RESIDUE_CHECK_EN defined, the check SHALL work as follows:
- On SYNC to RUN, load internal mod-3 and mod-7 trackers from cnt2[1:0] and cnt3[2:0].
- Each RUN cycle, advance each tracker by one with wrap (2 to 0, 6 to 0).
- If a tracker differs from its input, set err and enter ERR.
- ERR makes no pushes and exits only on rst.
REQ-025 Without RESIDUE_CHECK_EN, err SHALL be tied 0 and there SHALL be no ERR state or trackers.

Structure
REQ-026 Package residue_mon_pkg SHALL hold:
- the state enum;
- the evt_code constants;
- MOD_A=3 and MOD_B=7;
- the counter width 16.
REQ-027 The FIFO SHALL be a sub-module named evt_fifo, parameterised by data width and DEPTH.

Verification
REQ-028 Scenario 1: rst, then en=1 with cnt1 stepping 0,1,2,3... and matching residues, evt_ready=1. Required:
- SYNC for 1 cycle, then RUN.
- Events at cnt1=3 (01), 6 (01), 7 (10), 9 (01), 21 (11).
REQ-029 Scenario 2: evt_ready=0 with DEPTH=4, stepping through events. Required:
- First 4 events are held.
- 5th event sets overflow; drop_total=1, evt_total=4.
- Raising evt_ready drains 4 entries in order.
REQ-030 Scenario 3: FIFO full with evt_ready=1 on the same cycle as a new event. Required: push accepted, drop_total unchanged.
REQ-031 Scenario 4: cnt1 steps from all-ones to 0 while in SYNC. Required: move to RUN.
REQ-032 Scenario 5: rst pulsed mid-stream with 2 entries queued. Required: evt_valid=0 immediately, both totals 0, state IDLE.
REQ-033 Scenario 6 (RESIDUE_CHECK_EN defined): in RUN, force cnt2=1 where 0 is expected. Required: err=1 next cycle, no further events until rst.
